// File: rtl/move_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : move_scheduler
// Purpose  : Arbitrates local/remote Go moves, runs the board updater, commits
//            the result, triggers the transmitter; tracks turn/passes/game end.
// Options  : define UPD_TIMEOUT_EN to enable the updater watchdog timer.
// Revision : 1.0 - initial release
// ============================================================================
module move_scheduler #(
  parameter int         NUM_POINTS  = 81,
  parameter logic [7:0] PASS_CODE   = 8'hFF,
  parameter int         UPD_TIMEOUT = 65_000
) (
  input  logic       clk_in,
  input  logic       rst_in_n,
  input  logic       my_color,
  input  logic       local_valid,
  input  logic [7:0] local_move,
  output logic       local_ready,
  input  logic       remote_valid,
  input  logic [7:0] remote_move,
  output logic       upd_start,
  output logic [7:0] upd_move,
  output logic       upd_turn,
  input  logic       upd_done,
  input  logic       upd_illegal,
  output logic       commit,
  output logic       tx_start,
  output logic [7:0] tx_move,
  input  logic       tx_busy,
  output logic       turn,
  output logic       game_over,
  output logic       reject,
  output logic       err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_UPD_START = 3'd1,
    S_UPD_WAIT  = 3'd2,
    S_COMMIT    = 3'd3,
    S_TX_START  = 3'd4,
    S_TX_WAIT   = 3'd5,
    S_OVER      = 3'd6
  } state_t;

  localparam logic [8:0] c_num_points = 9'(NUM_POINTS);

  state_t     r_state;
  logic       r_turn;
  logic       r_game_over;
  logic [1:0] r_pass_cnt;
  logic [7:0] r_upd_move;
  logic       r_upd_turn;
  logic [7:0] r_move;
  logic       r_is_local;
  logic [7:0] r_tx_move;
  logic       r_tx_seen;
  logic       r_tx_cnt;

  state_t     w_state_nxt;
  logic       w_local_ready;
  logic       w_reject;
  logic       w_upd_start;
  logic       w_commit;
  logic       w_tx_start;
  logic       w_latch_pt;
  logic       w_latch_pass;
  logic       w_flip;
  logic       w_set_over;
  logic       w_clr_pass;
  logic       w_my_turn;
  logic [7:0] w_code;
  logic       w_is_pass;
  logic       w_code_ok;
  logic [1:0] w_pass_nxt;

`ifdef UPD_TIMEOUT_EN
  localparam int                 c_tmr_w    = $clog2(UPD_TIMEOUT + 1);
  localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(UPD_TIMEOUT - 1);

  logic [c_tmr_w-1:0] r_timer;
  logic               r_err_timeout;
  logic               w_tmr_expired;
`endif

  // Only the side whose turn it is can be accepted; the other is refused.
  assign w_my_turn  = (r_turn == my_color);
  assign w_code     = w_my_turn ? local_move : remote_move;
  assign w_is_pass  = (w_code == PASS_CODE);
  assign w_code_ok  = ({1'b0, w_code} < c_num_points) || w_is_pass;
  assign w_pass_nxt = r_pass_cnt + 2'd1;

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_local_ready = 1'b0;
    w_reject      = 1'b0;
    w_upd_start   = 1'b0;
    w_commit      = 1'b0;
    w_tx_start    = 1'b0;
    w_latch_pt    = 1'b0;
    w_latch_pass  = 1'b0;
    w_flip        = 1'b0;
    w_set_over    = 1'b0;
    w_clr_pass    = 1'b0;
`ifdef UPD_TIMEOUT_EN
    w_tmr_expired = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (w_my_turn) begin
          if (remote_valid) w_reject = 1'b1;
          if (local_valid) begin
            w_local_ready = 1'b1;
            if (!w_code_ok)     w_reject     = 1'b1;
            else if (w_is_pass) w_latch_pass = 1'b1;
            else                w_latch_pt   = 1'b1;
          end
        end else begin
          if (local_valid) begin
            w_local_ready = 1'b1;
            w_reject      = 1'b1;
          end
          if (remote_valid) begin
            if (!w_code_ok)     w_reject     = 1'b1;
            else if (w_is_pass) w_latch_pass = 1'b1;
            else                w_latch_pt   = 1'b1;
          end
        end
        if (w_latch_pt) begin
          w_state_nxt = S_UPD_START;
        end else if (w_latch_pass) begin
          if (w_pass_nxt == 2'd2) begin
            w_set_over  = 1'b1;
            w_state_nxt = w_my_turn ? S_TX_START : S_OVER;
          end else begin
            w_flip      = 1'b1;
            w_state_nxt = w_my_turn ? S_TX_START : S_IDLE;
          end
        end
      end
      S_UPD_START: begin
        w_upd_start = 1'b1;
        w_state_nxt = S_UPD_WAIT;
      end
      S_UPD_WAIT: begin
        if (upd_done) begin
          w_reject    = upd_illegal;
          w_state_nxt = upd_illegal ? S_IDLE : S_COMMIT;
        end
`ifdef UPD_TIMEOUT_EN
        else if (r_timer == c_tmr_last) begin
          w_tmr_expired = 1'b1;
          w_reject      = 1'b1;
          w_state_nxt   = S_IDLE;
        end
`endif
      end
      S_COMMIT: begin
        w_commit    = 1'b1;
        w_flip      = 1'b1;
        w_clr_pass  = 1'b1;
        w_state_nxt = r_is_local ? S_TX_START : S_IDLE;
      end
      S_TX_START: begin
        if (!tx_busy) begin
          w_tx_start  = 1'b1;
          w_state_nxt = S_TX_WAIT;
        end
      end
      S_TX_WAIT: begin
        // A transmitter that never raises busy is released after two cycles.
        if (!tx_busy && (r_tx_seen || r_tx_cnt)) begin
          w_state_nxt = r_game_over ? S_OVER : S_IDLE;
        end
      end
      S_OVER: begin
        if (local_valid) begin
          w_local_ready = 1'b1;
          w_reject      = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (remote_valid && (r_state != S_IDLE)) w_reject = 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_turn      <= 1'b0;
      r_game_over <= 1'b0;
      r_pass_cnt  <= 2'd0;
      r_upd_move  <= 8'd0;
      r_upd_turn  <= 1'b0;
      r_move      <= 8'd0;
      r_is_local  <= 1'b0;
      r_tx_move   <= 8'd0;
      r_tx_seen   <= 1'b0;
      r_tx_cnt    <= 1'b0;
    end else begin
      if (w_latch_pt) begin
        r_upd_move <= w_code;
        r_upd_turn <= r_turn;
      end
      if (w_latch_pt || w_latch_pass) begin
        r_move     <= w_code;
        r_is_local <= w_my_turn;
      end
      if (w_latch_pass)    r_pass_cnt <= w_pass_nxt;
      else if (w_clr_pass) r_pass_cnt <= 2'd0;
      if (w_flip)     r_turn      <= ~r_turn;
      if (w_set_over) r_game_over <= 1'b1;
      if (w_tx_start) begin
        r_tx_move <= r_move;
        r_tx_seen <= 1'b0;
        r_tx_cnt  <= 1'b0;
      end else if (r_state == S_TX_WAIT) begin
        if (tx_busy) r_tx_seen <= 1'b1;
        r_tx_cnt <= 1'b1;
      end
    end
  end

`ifdef UPD_TIMEOUT_EN
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_timer       <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      if (r_state == S_UPD_START)     r_timer <= '0;
      else if (r_state == S_UPD_WAIT) r_timer <= r_timer + 1'b1;
      if (w_tmr_expired) r_err_timeout <= 1'b1;
    end
  end
  assign err_timeout = r_err_timeout;
`else
  // Watchdog absent: the flag is constant low.
  assign err_timeout = (UPD_TIMEOUT < 0);
`endif

  assign local_ready = w_local_ready;
  assign reject      = w_reject;
  assign upd_start   = w_upd_start;
  assign commit      = w_commit;
  assign tx_start    = w_tx_start;
  assign upd_move    = r_upd_move;
  assign upd_turn    = r_upd_turn;
  // The move is presented alongside tx_start, then held until the next one.
  assign tx_move     = w_tx_start ? r_move : r_tx_move;
  assign turn        = r_turn;
  assign game_over   = r_game_over;

endmodule
`default_nettype wire
